uart_tx_serializer: RTL and testbench

- Downstream stage of the terminal buffer: consumes its byte/valid pulses and serializes each byte onto the UART TX line as 8N1 (or 8N2) frames, LSB first.
- Returns a one-cycle done pulse per completed frame; the terminal buffer's refresh and cursor sequencers wait on this pulse.
- A one-entry holding register absorbs one byte offered while a frame is in flight.

---
 rtl/uart_tx_serializer.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1/8N2 UART transmitter, LSB first, with a one-byte holding register.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_byte,
  input  logic       i_byte_v,
  output logic       o_byte_done,
  output logic       o_busy,
  output logic       o_overrun,
  output logic       o_tx
);

  localparam int unsigned   BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          ovr_q, ovr_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic       bit_end;
  logic       frame_end;
  logic       load;
  logic [7:0] load_byte;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign frame_end = (state_q == S_STOP) && bit_end && (stop_q == STOP_LAST);

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    done_d      = 1'b0;
    ovr_d       = 1'b0;
    load        = 1'b0;
    load_byte   = '0;
`ifdef UART_TX_PARITY_EN
    par_d       = par_q;
`endif

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (i_byte_v) begin
          load      = 1'b1;
          load_byte = i_byte;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (frame_end) begin
          done_d = 1'b1;
          stop_d = 1'b0;
          if (hold_full_q) begin
            load      = 1'b1;
            load_byte = hold_q;
          end else if (i_byte_v) begin
            load      = 1'b1;
            load_byte = i_byte;
          end else begin
            state_d = S_IDLE;
          end
        end else if (bit_end) begin
          stop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // At frame end a full holding register drains into the shifter, so the offered byte refills it.
    if (i_byte_v && (state_q != S_IDLE)) begin
      if (frame_end) begin
        if (hold_full_q) hold_d = i_byte;
      end else if (!hold_full_q) begin
        hold_d      = i_byte;
        hold_full_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (frame_end && hold_full_q) hold_full_d = i_byte_v;

    if (load) begin
      state_d = S_START;
      baud_d  = '0;
      bit_d   = '0;
      stop_d  = 1'b0;
      shift_d = load_byte;
`ifdef UART_TX_PARITY_EN
      par_d   = ^load_byte;
`endif
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE) | hold_full_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      stop_q      <= stop_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
`ifdef UART_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign o_tx        = tx_q;
  assign o_byte_done = done_q;
  assign o_busy      = busy_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (1 and 2 stop bits) checked every cycle
// against a frame-timing model, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_uart_tx_serializer;
  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int F1 = (9 + PAR + 1) * C;
  localparam int F2 = (9 + PAR + 2) * C;
  localparam int P1 = F1 / C;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] i_byte = '0;
  logic       i_byte_v = 1'b0;
  logic       o_done1, o_busy1, o_ovr1, o_tx1;
  logic       o_done2, o_busy2, o_ovr2, o_tx2;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(C), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_byte(i_byte), .i_byte_v(i_byte_v),
    .o_byte_done(o_done1), .o_busy(o_busy1), .o_overrun(o_ovr1), .o_tx(o_tx1));

  uart_tx_serializer #(.CLKS_PER_BIT(C), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .i_byte(i_byte), .i_byte_v(i_byte_v),
    .o_byte_done(o_done2), .o_busy(o_busy2), .o_overrun(o_ovr2), .o_tx(o_tx2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Frame-level model: a frame started at edge S occupies edges S..S+F-1 and ends at edge S+F.
  bit       m_act[2];
  bit       m_hf[2];
  bit       m_done[2];
  bit       m_ovr[2];
  int       m_start[2];
  logic [7:0] m_cur[2];
  logic [7:0] m_hb[2];
  int       mcyc = 0;

  function automatic int flen(input int d);
    return (d == 0) ? F1 : F2;
  endfunction

  function automatic logic exp_tx(input int d);
    int k;
    if (!m_act[d]) return 1'b1;
    k = (mcyc - m_start[d]) / C;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[d][k-1];
    if (PAR == 1 && k == 9) return ^m_cur[d];
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_act[d] = 0; m_hf[d] = 0; m_done[d] = 0; m_ovr[d] = 0;
      end
    end else begin
      mcyc++;
      for (int d = 0; d < 2; d++) begin
        m_done[d] = 0;
        m_ovr[d]  = 0;
        if (m_act[d] && (mcyc - m_start[d] == flen(d))) begin
          m_done[d] = 1;
          if (m_hf[d]) begin
            m_cur[d] = m_hb[d]; m_start[d] = mcyc;
            if (i_byte_v) m_hb[d] = i_byte; else m_hf[d] = 0;
          end else if (i_byte_v) begin
            m_cur[d] = i_byte; m_start[d] = mcyc;
          end else begin
            m_act[d] = 0;
          end
        end else if (!m_act[d]) begin
          if (i_byte_v) begin
            m_act[d] = 1; m_cur[d] = i_byte; m_start[d] = mcyc;
          end
        end else if (i_byte_v) begin
          if (!m_hf[d]) begin
            m_hf[d] = 1; m_hb[d] = i_byte;
          end else begin
            m_ovr[d] = 1;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("tx1",   o_tx1,   exp_tx(0));
    check("done1", o_done1, m_done[0]);
    check("busy1", o_busy1, m_act[0] | m_hf[0]);
    check("ovr1",  o_ovr1,  m_ovr[0]);
    check("tx2",   o_tx2,   exp_tx(1));
    check("done2", o_done2, m_done[1]);
    check("busy2", o_busy2, m_act[1] | m_hf[1]);
    check("ovr2",  o_ovr2,  m_ovr[1]);
  end

  // Directed-scenario recorder; t_rel counts edges after the test's first sampled byte (E0).
  int   t_rel;
  int   d1_q[$], d2_q[$], ov1_q[$];
  logic tx1s[64];
  logic tx2s[64];
  logic bz1s[256];
  bit   dense = 0;

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [7:0] rx1(input int p0);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = tx1s[p0 + i];
    return b;
  endfunction

  task automatic step_to(input int k);
    while (t_rel < k) begin
      @(negedge clk);
      i_byte_v = 1'b0;
      i_byte   = 8'($urandom);
      t_rel++;
      if (o_done1) d1_q.push_back(t_rel);
      if (o_done2) d2_q.push_back(t_rel);
      if (o_ovr1)  ov1_q.push_back(t_rel);
      if (t_rel >= 0 && t_rel % C == 1 && t_rel / C < 64) begin
        tx1s[t_rel / C] = o_tx1;
        tx2s[t_rel / C] = o_tx2;
      end
      if (t_rel >= 0 && t_rel < 256) bz1s[t_rel] = o_busy1;
    end
  endtask

  task automatic offer_at(input int k, input logic [7:0] b);
    step_to(k - 1);
    i_byte   = b;
    i_byte_v = 1'b1;
  endtask

  task automatic begin_test(input logic [7:0] b);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    d1_q.delete(); d2_q.delete(); ov1_q.delete();
    t_rel    = -1;
    i_byte   = b;
    i_byte_v = 1'b1;
  endtask

  logic [10:0] pat55;

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_tx",   o_tx1,   1'b1);
    check("rst_busy", o_busy1, 1'b0);
    check("rst_done", o_done1, 1'b0);
    check("rst_ovr",  o_ovr1,  1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single frame 0x55
    pat55 = (PAR == 1) ? 11'b100_1010_1010 : 11'b110_1010_1010;
    begin_test(8'h55);
    step_to(60);
    check("A_done_at", qat(d1_q, 0), (PAR == 1) ? 44 : 40);
    check("A_done_n",  d1_q.size(), 1);
    for (int p = 0; p < 11; p++) check("A_bit", tx1s[p], pat55[p]);
    check("A_busy0",    bz1s[0], 1'b1);
    check("A_busyLast", bz1s[F1-1], 1'b1);
    check("A_busyEnd",  bz1s[F1], 1'b0);
    check("A_done2_at", qat(d2_q, 0), (PAR == 1) ? 48 : 44);

    // Back-to-back 0x48, 0x69
    begin_test(8'h48);
    offer_at(5, 8'h69);
    step_to(100);
    check("B_done0", qat(d1_q, 0), F1);
    check("B_done1", qat(d1_q, 1), 2 * F1);
    check("B_start", tx1s[P1], 1'b0);
    check("B_byte0", rx1(1), 8'h48);
    check("B_byte1", rx1(P1 + 1), 8'h69);
    check("B_novr",  ov1_q.size(), 0);

    // Overrun 0x01, 0x02, 0x03
    begin_test(8'h01);
    offer_at(5, 8'h02);
    offer_at(9, 8'h03);
    step_to(130);
    check("C_ovr_n",  ov1_q.size(), 1);
    check("C_ovr_at", qat(ov1_q, 0), 9);
    check("C_done_n", d1_q.size(), 2);
    check("C_byte0",  rx1(1), 8'h01);
    check("C_byte1",  rx1(P1 + 1), 8'h02);
    check("C_idle",   tx1s[2 * P1], 1'b1);

    // Frame-end collision: hold full with 0x02, 0x03 offered on the frame-end edge
    begin_test(8'h01);
    offer_at(5, 8'h02);
    offer_at(F1, 8'h03);
    step_to(3 * F1 + 10);
    check("D_done_n", d1_q.size(), 3);
    check("D_done2",  qat(d1_q, 2), 3 * F1);
    check("D_novr",   ov1_q.size(), 0);
    check("D_byte1",  rx1(P1 + 1), 8'h02);
    check("D_byte2",  rx1(2 * P1 + 1), 8'h03);

    // Two stop bits, parity bit position
    begin_test(8'h01);
    step_to(60);
    check("E_par01",  tx2s[9], 1'b1);
    check("E_stop01", tx2s[10], 1'b1);
    check("E_done01", qat(d2_q, 0), (PAR == 1) ? 48 : 44);
    begin_test(8'h03);
    step_to(60);
    check("E_par03",  tx2s[9], (PAR == 1) ? 1'b0 : 1'b1);
    check("E_done03", qat(d2_q, 0), (PAR == 1) ? 48 : 44);

    // Asynchronous reset mid-DATA of 0x41
    begin_test(8'h41);
    step_to(14);
    check("R_pre_tx", o_tx1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("R_tx1",  o_tx1, 1'b1);
    check("R_tx2",  o_tx2, 1'b1);
    check("R_busy", o_busy1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step_to(80);
    check("R_nodone1", d1_q.size(), 0);
    check("R_nodone2", d2_q.size(), 0);
    check("R_idle_busy", o_busy1, 1'b0);
    check("R_idle_tx",   o_tx1, 1'b1);

    // Randomized traffic with alternating sparse/dense offer rates and occasional resets
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (i % 600 == 0) dense = !dense;
      i_byte   = 8'($urandom);
      i_byte_v = ($urandom_range(0, dense ? 3 : 40) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    @(negedge clk);
    i_byte_v = 1'b0;
    repeat (150) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
